// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_arb_pkg
//  Purpose  : Shared types, widths and the round-robin pick helper for the
//             SPI bus arbiter.
//  Contents : spi_arb_state_t  - arbiter FSM state encoding
//             SPI_ARB_GAP_W    - width of the inter-transaction gap counter
//             SPI_ARB_TO_W     - width of the completion timeout counter
//             SPI_ARB_MAX_REQ  - largest supported requester count
//             rr_pick()        - cyclic first-set search from a pointer
//  Revision : 1.0  initial release
// ============================================================================
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RESP      = 3'd3,
        ST_GAP       = 3'd4
    } spi_arb_state_t;

    localparam int SPI_ARB_GAP_W   = 8;
    localparam int SPI_ARB_TO_W    = 32;
    localparam int SPI_ARB_MAX_REQ = 8;

    // Returns the index of the first set bit at or after ptr, searching
    // cyclically upward over 8 positions. Callers zero-pad valid above their
    // requester count; those padding bits are never selected, so the wrap
    // behaves exactly like a modulo-NUM_REQ search. If nothing is set the
    // pointer itself is returned and the caller must qualify with |valid.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] pick;
        pick = ptr;
        // Walk downward so the smallest offset is the last (winning) write.
        for (int k = SPI_ARB_MAX_REQ - 1; k >= 0; k--) begin
            idx = ptr + k[2:0];
            if (valid[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rr_arbiter
//  Purpose  : Combinational round-robin pick among NUM_REQ requesters.
//  Ports    : valid_i  [NUM_REQ]  request vector
//             ptr_i    [IDX_W]    highest-priority index this cycle
//             grant_o  [NUM_REQ]  one-hot grant (zero when nothing valid)
//             idx_o    [IDX_W]    binary index of the grant
//             any_o               at least one request is valid
//  Revision : 1.0  initial release
// ============================================================================
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [SPI_ARB_MAX_REQ-1:0] w_valid_pad;
    logic [2:0]                 w_ptr_pad;
    logic [2:0]                 w_pick;

    always_comb begin
        w_valid_pad              = '0;
        w_valid_pad[NUM_REQ-1:0] = valid_i;
        w_ptr_pad                = '0;
        w_ptr_pad[IDX_W-1:0]     = ptr_i;
    end

    assign w_pick  = rr_pick(w_valid_pad, w_ptr_pad);
    assign idx_o   = w_pick[IDX_W-1:0];
    assign any_o   = |valid_i;
    assign grant_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;

    // Upper pick bits are always zero for small requester counts.
    generate
        if (IDX_W < 3) begin : g_pick_hi
            logic [2-IDX_W:0] w_unused_pick_hi;
            assign w_unused_pick_hi = w_pick[2:IDX_W];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bus_arbiter
//  Purpose  : Shares one SPI master among NUM_REQ requesters. Each accepted
//             request becomes one SPI word transaction; the received word is
//             returned to the owner, followed by a GAP_CYCLES idle guard.
//  Ports    : clk, rst_n (async, active-low)
//             req_valid/req_ready/req_data/req_slave  requester side
//             rsp_valid (one-hot pulse), rsp_data, rsp_err  response side
//             spi_start/spi_tx_data/spi_slave_en  master control
//             spi_busy (observed only), spi_done, spi_rx_data  master status
//  Config   : SPI_ARB_TIMEOUT_EN - when defined, a WAIT_DONE phase lasting
//             TIMEOUT_CYCLES without spi_done ends with rsp_err=1.
//  Revision : 1.0  initial release
// ============================================================================
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_SLAVES     = 2,
    parameter int SLV_W          = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*SLV_W-1:0]      req_slave,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          spi_start,
    output logic [DATA_WIDTH-1:0]         spi_tx_data,
    output logic [NUM_SLAVES-1:0]         spi_slave_en,
    input  logic                          spi_busy,
    input  logic                          spi_done,
    input  logic [DATA_WIDTH-1:0]         spi_rx_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    spi_arb_state_t           state_q,  state_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]         owner_q,  owner_d;
    logic [DATA_WIDTH-1:0]    tx_q,     tx_d;
    logic [DATA_WIDTH-1:0]    rx_q,     rx_d;
    logic [SLV_W-1:0]         slave_q,  slave_d;
    logic                     err_q,    err_d;
    logic [SPI_ARB_GAP_W-1:0] gap_q,    gap_d;

    logic [NUM_REQ-1:0]       w_grant;
    logic [IDX_W-1:0]         w_win;
    logic                     w_any;
    logic                     w_hs;
    logic [DATA_WIDTH-1:0]    w_win_data;
    logic [SLV_W-1:0]         w_win_slave;
    logic                     w_win_bad;
    logic                     w_to_hit;

    // spi_busy is informational; the FSM alone decides when to launch.
    logic w_unused_busy;
    assign w_unused_busy = spi_busy;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_win),
        .any_o   (w_any)
    );

    // The grant only ever selects a valid requester, so any valid request
    // seen in IDLE is a handshake.
    assign w_hs        = (state_q == ST_IDLE) && w_any;
    assign w_win_data  = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
    assign w_win_slave = req_slave[w_win*SLV_W +: SLV_W];
    assign w_win_bad   = 32'(w_win_slave) >= 32'(NUM_SLAVES);

`ifdef SPI_ARB_TIMEOUT_EN
    logic [SPI_ARB_TO_W-1:0] to_q, to_d;

    // Counter value N+1 is reached on the (N+1)-th WAIT_DONE cycle, so the
    // hit fires on WAIT_DONE cycle TIMEOUT_CYCLES; spi_done on that same
    // cycle still takes priority in the FSM.
    assign w_to_hit = (to_q + SPI_ARB_TO_W'(1)) == SPI_ARB_TO_W'(TIMEOUT_CYCLES);

    always_comb begin
        to_d = to_q;
        if (state_q == ST_LAUNCH) begin
            to_d = '0;
        end else if (state_q == ST_WAIT_DONE) begin
            to_d = to_q + SPI_ARB_TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        slave_d  = slave_q;
        err_d    = err_q;
        gap_d    = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (w_hs) begin
                    owner_d = w_win;
                    tx_d    = w_win_data;
                    slave_d = w_win_slave;
                    if (w_win_bad) begin
                        // Unreachable slave: answer immediately, no SPI cycle.
                        rx_d    = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (spi_done) begin
                    rx_d    = spi_rx_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (w_to_hit) begin
                    rx_d    = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                gap_d    = '0;
                state_d  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == SPI_ARB_GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + SPI_ARB_GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            slave_q  <= '0;
            err_q    <= 1'b0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            slave_q  <= slave_d;
            err_q    <= err_d;
            gap_q    <= gap_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE) ? w_grant : '0;
    assign spi_start    = (state_q == ST_LAUNCH);
    assign spi_tx_data  = tx_q;
    assign spi_slave_en = ((state_q == ST_LAUNCH) || (state_q == ST_WAIT_DONE))
                          ? (NUM_SLAVES'(1) << slave_q) : '0;
    assign rsp_valid    = (state_q == ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign rsp_data     = rx_q;
    assign rsp_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_bus_arbiter
//  Purpose  : Self-checking bench for spi_bus_arbiter with a stub SPI master.
//             Expected responses are queued at handshake time and popped when
//             rsp_valid pulses. Timeout scenarios compile in only with
//             SPI_ARB_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_bus_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int NS  = 2;
    localparam int SW  = 2;
    localparam int GAP = 4;
    localparam int TO  = 16;

    typedef struct {
        logic [NR-1:0] owner;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR*SW-1:0] req_slave = '0;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             rsp_err;
    logic             spi_start;
    logic [DW-1:0]    spi_tx_data;
    logic [NS-1:0]    spi_slave_en;
    logic             spi_busy = 1'b0;
    logic             spi_done = 1'b0;
    logic [DW-1:0]    spi_rx_data = '0;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    exp_t    sb[$];

    logic    stub_en  = 1'b1;
    int      stub_lat = 3;
    logic [DW-1:0] stub_key = 16'hFFFF;

    spi_bus_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLV_W(SW),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_slave(req_slave),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .spi_start(spi_start), .spi_tx_data(spi_tx_data),
        .spi_slave_en(spi_slave_en), .spi_busy(spi_busy),
        .spi_done(spi_done), .spi_rx_data(spi_rx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub master: on a start seen in cycle L, pulses done in cycle
    // L+stub_lat with rx = tx ^ stub_key.
    initial begin : stub
        logic [DW-1:0] tx;
        forever begin
            @(negedge clk);
            if (stub_en && spi_start === 1'b1) begin
                tx = spi_tx_data;
                spi_busy = 1'b1;
                repeat (stub_lat) @(negedge clk);
                spi_rx_data = tx ^ stub_key;
                spi_done = 1'b1;
                @(negedge clk);
                spi_done = 1'b0;
                spi_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid} !== 8'h00) begin
            errors++; $display("FAIL reset_handshake got ready=%b rsp_valid=%b want 0", req_ready, rsp_valid);
        end
        checks++;
        if ({rsp_data, rsp_err} !== 17'h0) begin
            errors++; $display("FAIL reset_rsp got data=%h err=%b want 0", rsp_data, rsp_err);
        end
        checks++;
        if ({spi_start, spi_slave_en, spi_tx_data} !== 19'h0) begin
            errors++; $display("FAIL reset_spi got start=%b en=%b tx=%h want 0", spi_start, spi_slave_en, spi_tx_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (spi_start !== 1'b0 || rsp_valid !== 4'b0) begin
            errors++; $display("FAIL reset_release got start=%b rsp_valid=%b want 0", spi_start, rsp_valid);
        end
    endtask

    task automatic test_fairness();
        int k;
        int w;
        exp_t e;
        logic [DW-1:0] tx;
        stub_en = 1'b1;
        stub_lat = 3;
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = 16'h1000 * 16'(i + 1);
            req_slave[i*SW +: SW] = 2'(i % 2);
        end
        req_valid = 4'hF;
        #1;
        for (int n = 0; n < 8; n++) begin
            w = n % NR;
            k = 0;
            while (req_ready === 4'b0 && k < 50) begin @(negedge clk); #1; k++; end
            checks++;
            if (req_ready !== (4'b1 << w)) begin
                errors++; $display("FAIL fair_grant[%0d] got %b want %b", n, req_ready, 4'b1 << w);
            end
            tx = req_data[w*DW +: DW];
            sb.push_back('{owner: 4'b1 << w, data: tx ^ stub_key, err: 1'b0});
            @(posedge clk); @(negedge clk);
            req_data[w*DW +: DW] = tx + 16'h0101;
            k = 0;
            while (rsp_valid === 4'b0 && k < 100) begin @(negedge clk); k++; end
            checks++;
            if (k >= 100 || sb.size() == 0) begin
                errors++; $display("FAIL fair_rsp[%0d] got no response want one", n);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== e.owner || rsp_data !== e.data || rsp_err !== e.err) begin
                    errors++; $display("FAIL fair_rsp[%0d] got v=%b d=%h e=%b want v=%b d=%h e=%b",
                                       n, rsp_valid, rsp_data, rsp_err, e.owner, e.data, e.err);
                end
            end
            #1;
        end
        req_valid = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_single();
        int k;
        int lc;
        exp_t e;
        stub_en = 1'b1;
        stub_lat = 3;
        stub_key = 16'hA5A5 ^ 16'h3C3C;
        req_data[1*DW +: DW] = 16'hA5A5;
        req_slave[1*SW +: SW] = 2'd1;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL single_ready got %b want 0010", req_ready);
        end
        sb.push_back('{owner: 4'b0010, data: 16'h3C3C, err: 1'b0});
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        lc = cyc;
        checks++;
        if (spi_start !== 1'b1 || spi_tx_data !== 16'hA5A5 || spi_slave_en !== 2'b10) begin
            errors++; $display("FAIL single_launch got start=%b tx=%h en=%b want 1 a5a5 10",
                               spi_start, spi_tx_data, spi_slave_en);
        end
        @(negedge clk);
        checks++;
        if (spi_start !== 1'b0 || spi_tx_data !== 16'hA5A5 || spi_slave_en !== 2'b10) begin
            errors++; $display("FAIL single_hold got start=%b tx=%h en=%b want 0 a5a5 10",
                               spi_start, spi_tx_data, spi_slave_en);
        end
        k = 0;
        while (rsp_valid === 4'b0 && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (k >= 100 || sb.size() == 0) begin
            errors++; $display("FAIL single_rsp got no response want one");
        end else begin
            e = sb.pop_front();
            if (rsp_valid !== e.owner || rsp_data !== e.data || rsp_err !== e.err) begin
                errors++; $display("FAIL single_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b",
                                   rsp_valid, rsp_data, rsp_err, e.owner, e.data, e.err);
            end
        end
        checks++;
        if (cyc - lc !== stub_lat + 1) begin
            errors++; $display("FAIL single_latency got %0d want %0d", cyc - lc, stub_lat + 1);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_gap();
        int k;
        int cnt;
        logic en_seen;
        exp_t e;
        stub_en = 1'b1;
        stub_lat = 2;
        req_data[2*DW +: DW] = 16'h1234;
        req_slave[2*SW +: SW] = 2'd0;
        req_valid = 4'b0100;
        #1;
        sb.push_back('{owner: 4'b0100, data: 16'h1234 ^ stub_key, err: 1'b0});
        @(posedge clk); @(negedge clk);
        k = 0;
        while (rsp_valid === 4'b0 && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (k >= 100 || sb.size() == 0) begin
            errors++; $display("FAIL gap_rsp1 got no response want one");
        end else begin
            e = sb.pop_front();
            if (rsp_valid !== e.owner || rsp_data !== e.data || rsp_err !== e.err) begin
                errors++; $display("FAIL gap_rsp1 got v=%b d=%h e=%b want v=%b d=%h e=%b",
                                   rsp_valid, rsp_data, rsp_err, e.owner, e.data, e.err);
            end
        end
        cnt = 0;
        en_seen = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk); #1;
            if (req_ready !== 4'b0) break;
            cnt++;
            if (spi_slave_en !== 2'b00) en_seen = 1'b1;
            k++;
        end
        checks++;
        if (cnt !== GAP) begin
            errors++; $display("FAIL gap_len got %0d want %0d", cnt, GAP);
        end
        checks++;
        if (en_seen !== 1'b0) begin
            errors++; $display("FAIL gap_slave_en got active want 0");
        end
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL gap_regrant got %b want 0100", req_ready);
        end
        req_data[2*DW +: DW] = 16'h4321;
        sb.push_back('{owner: 4'b0100, data: 16'h4321 ^ stub_key, err: 1'b0});
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        k = 0;
        while (rsp_valid === 4'b0 && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (k >= 100 || sb.size() == 0) begin
            errors++; $display("FAIL gap_rsp2 got no response want one");
        end else begin
            e = sb.pop_front();
            if (rsp_valid !== e.owner || rsp_data !== e.data || rsp_err !== e.err) begin
                errors++; $display("FAIL gap_rsp2 got v=%b d=%h e=%b want v=%b d=%h e=%b",
                                   rsp_valid, rsp_data, rsp_err, e.owner, e.data, e.err);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_bad_slave();
        int starts;
        exp_t e;
        req_data[3*DW +: DW] = 16'hBEEF;
        req_slave[3*SW +: SW] = 2'd3;
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL bad_ready got %b want 1000", req_ready);
        end
        sb.push_back('{owner: 4'b1000, data: 16'h0000, err: 1'b1});
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        e = sb.pop_front();
        checks++;
        if (rsp_valid !== e.owner || rsp_data !== e.data || rsp_err !== e.err || spi_start !== 1'b0) begin
            errors++; $display("FAIL bad_rsp got v=%b d=%h e=%b start=%b want v=%b d=%h e=%b start=0",
                               rsp_valid, rsp_data, rsp_err, spi_start, e.owner, e.data, e.err);
        end
        starts = 0;
        repeat (6) begin
            @(negedge clk);
            if (spi_start === 1'b1) starts++;
        end
        checks++;
        if (starts !== 0) begin
            errors++; $display("FAIL bad_no_start got %0d starts want 0", starts);
        end
        repeat (4) @(negedge clk);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        int lc;
        exp_t e;
        logic [DW-1:0] d;
        for (int t = 0; t < 3; t++) begin
            // t=0: no done (timeout); t=1: normal; t=2: done on timeout cycle
            stub_en  = (t != 0);
            stub_lat = (t == 2) ? TO : 3;
            d = 16'h0F0F + 16'(t) * 16'h1111;
            req_data[t*DW +: DW] = d;
            req_slave[t*SW +: SW] = 2'(t % 2);
            req_valid = 4'b1 << t;
            k = 0;
            #1;
            while (req_ready === 4'b0 && k < 50) begin @(negedge clk); #1; k++; end
            sb.push_back('{owner: 4'b1 << t, data: (t == 0) ? 16'h0 : (d ^ stub_key),
                           err: (t == 0)});
            @(posedge clk); @(negedge clk);
            req_valid = '0;
            lc = cyc;
            k = 0;
            while (rsp_valid === 4'b0 && k < 100) begin @(negedge clk); k++; end
            checks++;
            if (k >= 100 || sb.size() == 0) begin
                errors++; $display("FAIL timeout_rsp[%0d] got no response want one", t);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== e.owner || rsp_data !== e.data || rsp_err !== e.err) begin
                    errors++; $display("FAIL timeout_rsp[%0d] got v=%b d=%h e=%b want v=%b d=%h e=%b",
                                       t, rsp_valid, rsp_data, rsp_err, e.owner, e.data, e.err);
                end
            end
            if (t != 1) begin
                checks++;
                if (cyc - lc !== TO + 1) begin
                    errors++; $display("FAIL timeout_latency[%0d] got %0d want %0d", t, cyc - lc, TO + 1);
                end
            end
            repeat (8) @(negedge clk);
        end
        stub_en = 1'b1;
    endtask
`endif

    task automatic test_reset_mid();
        int k;
        int rsps;
        exp_t e;
        stub_en = 1'b1;
        stub_lat = 2;
        // Normal transaction by req1 so the pointer moves to 2.
        req_data[1*DW +: DW] = 16'h7777;
        req_slave[1*SW +: SW] = 2'd1;
        req_valid = 4'b0010;
        k = 0;
        #1;
        while (req_ready === 4'b0 && k < 50) begin @(negedge clk); #1; k++; end
        sb.push_back('{owner: 4'b0010, data: 16'h7777 ^ stub_key, err: 1'b0});
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        k = 0;
        while (rsp_valid === 4'b0 && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (k >= 100 || sb.size() == 0) begin
            errors++; $display("FAIL rmid_pre_rsp got no response want one");
        end else begin
            e = sb.pop_front();
            if (rsp_valid !== e.owner || rsp_data !== e.data || rsp_err !== e.err) begin
                errors++; $display("FAIL rmid_pre_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b",
                                   rsp_valid, rsp_data, rsp_err, e.owner, e.data, e.err);
            end
        end
        repeat (8) @(negedge clk);
        // Stalled transaction by req2, interrupted by reset.
        stub_en = 1'b0;
        req_data[2*DW +: DW] = 16'h8888;
        req_slave[2*SW +: SW] = 2'd0;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL rmid_grant got %b want 0100", req_ready);
        end
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        rsps = 0;
`ifdef SPI_ARB_TIMEOUT_EN
        repeat (10) begin @(negedge clk); if (rsp_valid !== 4'b0) rsps++; end
`else
        repeat (40) begin @(negedge clk); if (rsp_valid !== 4'b0) rsps++; end
`endif
        checks++;
        if (rsps !== 0 || spi_slave_en !== 2'b01) begin
            errors++; $display("FAIL rmid_stall got rsps=%0d en=%b want 0 01", rsps, spi_slave_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_err, spi_start, spi_tx_data, spi_slave_en, req_ready} !== '0) begin
            errors++; $display("FAIL rmid_reset got v=%b d=%h e=%b start=%b tx=%h en=%b ready=%b want 0",
                               rsp_valid, rsp_data, rsp_err, spi_start, spi_tx_data, spi_slave_en, req_ready);
        end
        rsps = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid !== 4'b0) rsps++; end
        rst_n = 1'b1;
        stub_en = 1'b1;
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010 || rsps !== 0) begin
            errors++; $display("FAIL rmid_ptr got ready=%b rsps=%0d want 0010 0", req_ready, rsps);
        end
        sb.push_back('{owner: 4'b0010, data: 16'h7777 ^ stub_key, err: 1'b0});
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        k = 0;
        while (rsp_valid === 4'b0 && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (k >= 100 || sb.size() == 0) begin
            errors++; $display("FAIL rmid_post_rsp got no response want one");
        end else begin
            e = sb.pop_front();
            if (rsp_valid !== e.owner || rsp_data !== e.data || rsp_err !== e.err) begin
                errors++; $display("FAIL rmid_post_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b",
                                   rsp_valid, rsp_data, rsp_err, e.owner, e.data, e.err);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin : main
        test_reset();
        test_fairness();
        test_single();
        test_gap();
        test_bad_slave();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
